// File: rtl/instr_fetch_decode_pkg.sv
// Shared widths, ALU opcodes and condition codes for the ARM-subset front end.
// Everything here is imported by the fetch/decode files.
package instr_fetch_decode_pkg;

    localparam int FULLW = 32;
    localparam int REGAW = 4;
    localparam int ALUAW = 4;
    localparam bit IS_SIM = 1'b0;

    localparam logic [ALUAW-1:0] ALU_AND = 4'b0000;
    localparam logic [ALUAW-1:0] ALU_SUB = 4'b0010;
    localparam logic [ALUAW-1:0] ALU_ADD = 4'b0100;

    typedef enum logic [3:0] {
        COND_EQ = 4'h0, COND_NE = 4'h1, COND_CS = 4'h2, COND_CC = 4'h3,
        COND_MI = 4'h4, COND_PL = 4'h5, COND_VS = 4'h6, COND_VC = 4'h7,
        COND_HI = 4'h8, COND_LS = 4'h9, COND_GE = 4'hA, COND_LT = 4'hB,
        COND_GT = 4'hC, COND_LE = 4'hD, COND_AL = 4'hE, COND_NV = 4'hF
    } cond_e;

endpackage

// File: rtl/instr_fetch_decode_if.sv
// Bus between the PC/register-file side (master) and the fetch/decode block (slave).
interface instr_fetch_decode_if;
    import instr_fetch_decode_pkg::*;

    logic [FULLW-1:0] iaddr;
    logic [FULLW-1:0] wdata;
    logic             we;
    logic [3:0]       cpsr_flags;
    logic [FULLW-1:0] instr;
    logic [ALUAW-1:0] alu_op;
    logic [REGAW-1:0] rn;
    logic [REGAW-1:0] rd;
    logic             cpsr_we;
    logic             reg_we;
    logic             mem_we;
    logic             ib;
    logic [FULLW-1:0] bv;
    logic             bl;
    logic             ispb;

    modport master (
        output iaddr, wdata, we, cpsr_flags,
        input  instr, alu_op, rn, rd, cpsr_we, reg_we, mem_we, ib, bv, bl, ispb
    );

    modport slave (
        input  iaddr, wdata, we, cpsr_flags,
        output instr, alu_op, rn, rd, cpsr_we, reg_we, mem_we, ib, bv, bl, ispb
    );

endinterface

// File: rtl/instr_fetch_decode_dff.sv
// Single flop with asynchronous active-low clear; holds the branch-shadow flag.
module instr_fetch_decode_dff (
    input  logic clk_i,
    input  logic nreset_i,
    input  logic d_i,
    output logic q_o
);

    logic q_q;

    always_ff @(posedge clk_i or negedge nreset_i) begin
        if (!nreset_i) q_q <= 1'b0;
        else           q_q <= d_i;
    end

    assign q_o = q_q;

endmodule

// File: rtl/instr_fetch_decode_idec.sv
// Combinational instruction decoder: condition check, class decode and shadow squash.
module instr_fetch_decode_idec
    import instr_fetch_decode_pkg::*;
(
    input  logic [FULLW-1:0] instr_i,
    input  logic [3:0]       flags_i,
    input  logic             ispb_i,
    output logic [ALUAW-1:0] alu_op_o,
    output logic [REGAW-1:0] rn_o,
    output logic [REGAW-1:0] rd_o,
    output logic             cpsr_we_o,
    output logic             reg_we_o,
    output logic             mem_we_o,
    output logic             ib_o,
    output logic [FULLW-1:0] bv_o,
    output logic             bl_o
);

    function automatic logic cond_pass(input logic [3:0] cond, input logic [3:0] nzcv);
        logic n, z, c, v;
        {n, z, c, v} = nzcv;
        case (cond_e'(cond))
            COND_EQ: return z;
            COND_NE: return !z;
            COND_CS: return c;
            COND_CC: return !c;
            COND_MI: return n;
            COND_PL: return !n;
            COND_VS: return v;
            COND_VC: return !v;
            COND_HI: return c & !z;
            COND_LS: return !c | z;
            COND_GE: return n == v;
            COND_LT: return n != v;
            COND_GT: return !z & (n == v);
            COND_LE: return z | (n != v);
            COND_AL: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    logic kill;
    logic cpsr_we_raw, reg_we_raw, mem_we_raw, ib_raw, bl_raw;

    assign rn_o = instr_i[19:16];
    assign rd_o = instr_i[15:12];
    assign kill = ispb_i | !cond_pass(instr_i[31:28], flags_i);

    always_comb begin
        alu_op_o    = ALU_AND;
        bv_o        = '0;
        cpsr_we_raw = 1'b0;
        reg_we_raw  = 1'b0;
        mem_we_raw  = 1'b0;
        ib_raw      = 1'b0;
        bl_raw      = 1'b0;
        if (instr_i[27:26] == 2'b00) begin
            alu_op_o    = instr_i[24:21];
            cpsr_we_raw = instr_i[20];
            // TST/TEQ/CMP/CMN only set flags
            reg_we_raw  = (instr_i[24:23] != 2'b10);
        end else if (instr_i[27:26] == 2'b01) begin
            alu_op_o   = instr_i[23] ? ALU_ADD : ALU_SUB;
            reg_we_raw = instr_i[20];
            mem_we_raw = !instr_i[20];
        end else if (instr_i[27:25] == 3'b101) begin
            ib_raw     = 1'b1;
            bl_raw     = instr_i[24];
            reg_we_raw = instr_i[24];
            bv_o       = {{(FULLW-26){instr_i[23]}}, instr_i[23:0], 2'b00};
        end
    end

    assign cpsr_we_o = cpsr_we_raw & !kill;
    assign reg_we_o  = reg_we_raw  & !kill;
    assign mem_we_o  = mem_we_raw  & !kill;
    assign ib_o      = ib_raw      & !kill;
    assign bl_o      = bl_raw      & !kill;

endmodule

// File: rtl/instr_fetch_decode_ram.sv
// Word-organised instruction memory: combinational read, synchronous write, no reset.
module instr_fetch_decode_ram
    import instr_fetch_decode_pkg::*;
#(
    parameter int WORDS = 256,
    parameter int AW    = $clog2(WORDS)
) (
    input  logic             clk_i,
    input  logic             we_i,
    input  logic [AW-1:0]    addr_i,
    input  logic [FULLW-1:0] wdata_i,
    output logic [FULLW-1:0] rdata_o
);

    logic [FULLW-1:0] mem_q [WORDS];

    always_ff @(posedge clk_i) begin
        if (we_i) mem_q[addr_i] <= wdata_i;
    end

    assign rdata_o = mem_q[addr_i];

endmodule

// File: rtl/instr_fetch_decode.sv
// Front end of the single-cycle CPU: instruction RAM, decoder and the
// registered taken-branch flag that squashes the fetch after a branch.
module instr_fetch_decode
    import instr_fetch_decode_pkg::*;
#(
    parameter int MEM_WORDS = 256
) (
    input  logic                 clk,
    input  logic                 nreset,
    instr_fetch_decode_if.slave  bus
);

    localparam int IDX_W = $clog2(MEM_WORDS);

    logic [IDX_W-1:0] widx;
    logic             unused_addr_bits;

    // Upper address bits are dropped so fetches wrap around the array
    assign widx             = bus.iaddr[IDX_W+1:2];
    assign unused_addr_bits = ^{bus.iaddr[FULLW-1:IDX_W+2], bus.iaddr[1:0]};

    instr_fetch_decode_ram #(.WORDS(MEM_WORDS), .AW(IDX_W)) u_ram (
        .clk_i   (clk),
        .we_i    (bus.we),
        .addr_i  (widx),
        .wdata_i (bus.wdata),
        .rdata_o (bus.instr)
    );

    instr_fetch_decode_idec u_idec (
        .instr_i   (bus.instr),
        .flags_i   (bus.cpsr_flags),
        .ispb_i    (bus.ispb),
        .alu_op_o  (bus.alu_op),
        .rn_o      (bus.rn),
        .rd_o      (bus.rd),
        .cpsr_we_o (bus.cpsr_we),
        .reg_we_o  (bus.reg_we),
        .mem_we_o  (bus.mem_we),
        .ib_o      (bus.ib),
        .bv_o      (bus.bv),
        .bl_o      (bus.bl)
    );

    instr_fetch_decode_dff u_ispb (
        .clk_i    (clk),
        .nreset_i (nreset),
        .d_i      (bus.ib),
        .q_o      (bus.ispb)
    );

endmodule

// File: tb/tb_instr_fetch_decode.sv
// Directed bench for instr_fetch_decode: program load, decode classes, branch shadow, reset.
module tb_instr_fetch_decode;

    logic clk;
    logic nreset;
    int   ntests;
    int   nfail;

    instr_fetch_decode_if bus ();

    instr_fetch_decode dut (
        .clk    (clk),
        .nreset (nreset),
        .bus    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        ntests++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: observed %08h expected %08h", tag, obs, exp);
        end
    endtask

    task automatic load(input int idx, input logic [31:0] val);
        bus.iaddr = 32'(idx * 4);
        bus.wdata = val;
        bus.we    = 1'b1;
        @(posedge clk);
        #1;
        bus.we    = 1'b0;
    endtask

    // Advance one clock, then apply a new fetch address and flags
    task automatic step(input logic [31:0] addr, input logic [3:0] flags);
        @(posedge clk);
        #1;
        bus.iaddr      = addr;
        bus.cpsr_flags = flags;
        #1;
    endtask

    initial begin
        ntests = 0;
        nfail  = 0;
        nreset = 1'b0;
        bus.iaddr      = '0;
        bus.wdata      = '0;
        bus.we         = 1'b0;
        bus.cpsr_flags = 4'b0000;
        #2;
        chk("reset_ispb", 32'(bus.ispb), 32'd0);

        // Program load while held in reset keeps the shadow flag clean
        @(posedge clk);
        #1;
        load(0, 32'hE0812003);
        load(1, 32'hE1530004);
        load(2, 32'h0A000002);
        load(3, 32'hEBFFFFFE);
        load(4, 32'hE5812000);
        load(5, 32'hE5112000);
        load(6, 32'h40812003);
        load(7, 32'hA0812003);
        load(8, 32'hE0812003);

        // Read during write returns the old word until the edge
        bus.iaddr = 32'd32;
        bus.wdata = 32'hEC000000;
        bus.we    = 1'b1;
        #1;
        chk("rdw_old", bus.instr, 32'hE0812003);
        @(posedge clk);
        #1;
        bus.we = 1'b0;
        chk("rdw_new", bus.instr, 32'hEC000000);
        chk("ispb_in_reset", 32'(bus.ispb), 32'd0);
        nreset = 1'b1;

        step(32'd0, 4'b0000);
        chk("add_instr",  bus.instr, 32'hE0812003);
        chk("add_aluop",  32'(bus.alu_op), 32'h4);
        chk("add_rn",     32'(bus.rn), 32'd1);
        chk("add_rd",     32'(bus.rd), 32'd2);
        chk("add_regwe",  32'(bus.reg_we), 32'd1);
        chk("add_cpsrwe", 32'(bus.cpsr_we), 32'd0);
        chk("add_memwe",  32'(bus.mem_we), 32'd0);
        chk("add_ib",     32'(bus.ib), 32'd0);

        step(32'd4, 4'b0000);
        chk("cmp_aluop",  32'(bus.alu_op), 32'hA);
        chk("cmp_regwe",  32'(bus.reg_we), 32'd0);
        chk("cmp_cpsrwe", 32'(bus.cpsr_we), 32'd1);
        chk("cmp_rn",     32'(bus.rn), 32'd3);

        step(32'd8, 4'b0100);
        chk("beq_t_ib", 32'(bus.ib), 32'd1);
        chk("beq_t_bv", bus.bv, 32'h00000008);
        chk("beq_t_bl", 32'(bus.bl), 32'd0);
        chk("beq_t_regwe", 32'(bus.reg_we), 32'd0);

        step(32'd0, 4'b0000);
        chk("shadow_ispb",  32'(bus.ispb), 32'd1);
        chk("shadow_regwe", 32'(bus.reg_we), 32'd0);
        chk("shadow_aluop", 32'(bus.alu_op), 32'h4);
        chk("shadow_rd",    32'(bus.rd), 32'd2);

        step(32'd8, 4'b0000);
        chk("beq_nt_ispb", 32'(bus.ispb), 32'd0);
        chk("beq_nt_ib",   32'(bus.ib), 32'd0);
        chk("beq_nt_bv",   bus.bv, 32'h00000008);

        step(32'd12, 4'b0000);
        chk("bl_ib",    32'(bus.ib), 32'd1);
        chk("bl_bl",    32'(bus.bl), 32'd1);
        chk("bl_regwe", 32'(bus.reg_we), 32'd1);
        chk("bl_bv",    bus.bv, 32'hFFFFFFF8);

        // A branch in the shadow of a taken branch is itself killed
        step(32'd12, 4'b0000);
        chk("bl2_ispb",  32'(bus.ispb), 32'd1);
        chk("bl2_ib",    32'(bus.ib), 32'd0);
        chk("bl2_bl",    32'(bus.bl), 32'd0);
        chk("bl2_regwe", 32'(bus.reg_we), 32'd0);

        step(32'd16, 4'b0000);
        chk("str_ispb",  32'(bus.ispb), 32'd0);
        chk("str_memwe", 32'(bus.mem_we), 32'd1);
        chk("str_regwe", 32'(bus.reg_we), 32'd0);
        chk("str_aluop", 32'(bus.alu_op), 32'h4);

        step(32'd20, 4'b0000);
        chk("ldr_regwe", 32'(bus.reg_we), 32'd1);
        chk("ldr_memwe", 32'(bus.mem_we), 32'd0);
        chk("ldr_aluop", 32'(bus.alu_op), 32'h2);

        step(32'd12, 4'b0000);
        chk("bl3_ib", 32'(bus.ib), 32'd1);
        step(32'd0, 4'b0000);
        chk("pre_rst_ispb", 32'(bus.ispb), 32'd1);
        nreset = 1'b0;
        #1;
        chk("async_rst_ispb", 32'(bus.ispb), 32'd0);
        chk("async_rst_regwe", 32'(bus.reg_we), 32'd1);
        nreset = 1'b1;

        step(32'd24, 4'b0000);
        chk("mi_fail_regwe",  32'(bus.reg_we), 32'd0);
        chk("mi_fail_cpsrwe", 32'(bus.cpsr_we), 32'd0);
        chk("mi_fail_memwe",  32'(bus.mem_we), 32'd0);
        chk("mi_fail_ib",     32'(bus.ib), 32'd0);
        chk("mi_fail_bl",     32'(bus.bl), 32'd0);
        chk("mi_fail_aluop",  32'(bus.alu_op), 32'h4);

        step(32'd24, 4'b1000);
        chk("mi_pass_regwe", 32'(bus.reg_we), 32'd1);

        step(32'd28, 4'b1001);
        chk("ge_pass_regwe", 32'(bus.reg_we), 32'd1);
        step(32'd28, 4'b1000);
        chk("ge_fail_regwe", 32'(bus.reg_we), 32'd0);

        step(32'd32, 4'b0000);
        chk("other_regwe", 32'(bus.reg_we), 32'd0);
        chk("other_aluop", 32'(bus.alu_op), 32'h0);
        chk("other_bv",    bus.bv, 32'h0);
        chk("other_ib",    32'(bus.ib), 32'd0);

        // Address wraps: 0x404 maps to word 1
        step(32'h00000404, 4'b0000);
        chk("wrap_instr", bus.instr, 32'hE1530004);

        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end

endmodule

// File: doc/instr_fetch_decode.md
Name: instr_fetch_decode

Overview:
Front end of the single-cycle ARM-subset CPU. It holds the word-organised instruction memory and a 1-bit "previous instruction was a branch" flag register. A combinational 32-bit decoder turns the fetched word, the CPSR flags and that flag into register-file, ALU, CPSR, data-memory and branch controls. The register file / PC block drives iaddr and consumes rn/rd/reg_we/ib/bv/bl.

Parameters:
FULLW, 32, data/instruction/address width (shared constant)
REGAW, 4, register-address width (shared constant)
ALUAW, 4, ALU opcode width (shared constant)
MEM_WORDS, 256, instruction-memory depth in 32-bit words

Ports:
clk  in  1  system clock; all state updates on rising edge
nreset  in  1  asynchronous active-low reset; clears the branch flag
iaddr  in  32  byte address of instruction (PC)
wdata  in  32  program-load write data
we  in  1  program-load write enable
cpsr_flags  in  4  {N,Z,C,V} = CPSR[31:28]
instr  out  32  fetched instruction word
alu_op  out  4  ALU opcode
rn  out  4  first source register (instr[19:16])
rd  out  4  destination/second register (instr[15:12])
cpsr_we  out  1  update CPSR flags
reg_we  out  1  register-file write enable
mem_we  out  1  data-memory write enable
ib  out  1  branch taken this cycle
bv  out  32  signed branch byte offset
bl  out  1  branch-with-link
ispb  out  1  registered ib (squash flag)

Behaviour:
- Memory: word index iaddr[log2(MEM_WORDS)+1:2]; upper bits are ignored, so addresses wrap. Read is combinational (instr follows iaddr in the same cycle). Write is synchronous on clk when we=1. Read during write returns the old word until the edge. Contents are not reset.
- ispb register: on each rising edge ispb <= ib. nreset=0 forces ispb=0 immediately.
- rn and rd are always driven from instr fields, even when the instruction is squashed.
- Squash: if ispb=1 or the condition fails, then cpsr_we, reg_we, mem_we, ib and bl are all 0. alu_op and bv are still decoded.
- Condition cond=instr[31:28] is evaluated on {N,Z,C,V}:
  - 0 EQ: Z; 1 NE: !Z; 2 CS: C; 3 CC: !C
  - 4 MI: N; 5 PL: !N; 6 VS: V; 7 VC: !V
  - 8 HI: C&!Z; 9 LS: !C|Z; A GE: N==V; B LT: N!=V
  - C GT: !Z&(N==V); D LE: Z|(N!=V); E AL: 1; F: never
- Data processing (instr[27:26]=00):
  - alu_op=instr[24:21]; cpsr_we=instr[20]
  - reg_we=1 except for opcodes 1000–1011 (TST/TEQ/CMP/CMN), where reg_we=0
  - mem_we=0
- Load/store (instr[27:26]=01):
  - alu_op=0100 (ADD) if U=instr[23]=1, else 0010 (SUB)
  - L=instr[20]: reg_we=L, mem_we=!L; cpsr_we=0
- Branch (instr[27:25]=101):
  - ib=1; bl=instr[24]; reg_we=bl (link write); cpsr_we=0, mem_we=0; alu_op=0000
  - bv = sign_extend(instr[23:0])<<2, computed whenever the encoding is a branch
- All other encodings: every enable 0, alu_op=0000, bv=0.
- A taken branch therefore kills exactly the one following fetch. A branch in the shadow of another branch is itself squashed.
- Reset mid-operation clears ispb only. Decode outputs remain a pure function of the inputs.

Decomposition:
- Shared defines package: FULLW, REGAW, ALUAW, ALU opcode constants, condition-code constants, IS_SIM.
- Sub-modules: word RAM, 1-bit dff with async active-low clear, and combinational decoder (idec-style), instantiated in this top.
- Decoder contains one function for condition evaluation.

Test Plan:
- Load word 0 with 0xE0812003 (ADD r2,r1,r3, AL), iaddr=0 -> instr=0xE0812003, alu_op=0100, rn=1, rd=2, reg_we=1, cpsr_we=0, mem_we=0.
- 0xE1530004 (CMP r3,r4) -> alu_op=1010, reg_we=0, cpsr_we=1.
- 0x0A000002 (BEQ +8):
  - flags Z=1 -> ib=1, bv=0x00000008, bl=0; next cycle ispb=1 and the following ADD has reg_we=0.
  - flags Z=0 -> ib=0.
- 0xEBFFFFFE (BL −8) -> ib=1, bl=1, reg_we=1, bv=0xFFFFFFF8.
- 0xE5812000 (STR) -> mem_we=1, reg_we=0, alu_op=0100. 0xE5112000 (LDR, U=0) -> reg_we=1, mem_we=0, alu_op=0010.
- Assert nreset=0 while ispb=1 -> ispb=0 immediately, without waiting for a clock edge; an MI instruction with N=0 -> all enables 0.
